// File: rtl/raster_pkg.sv
// Shared types and default sizing for the triangle raster scheduler.
//
// Contents:
//   DEF_* constants - default widths and the default interpolator latency.
//   raster_state_e  - scheduler FSM states (IDLE, SCAN, DRAIN).
//   tri_desc_t      - every field of one triangle descriptor.
//   track_ent_t     - one latency-tracker entry {v, px, py}.
//
// The struct field widths come from the DEF_* constants. A build that changes
// the top-level width parameters must change these constants to match.
package raster_pkg;

  localparam int DEF_XWIDTH     = 16;
  localparam int DEF_YWIDTH     = 16;
  localparam int DEF_VAL_WIDTH  = 16;
  localparam int DEF_AINV_WIDTH = 16;
  localparam int DEF_PIX_W      = 10;
  localparam int DEF_LATENCY    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } raster_state_e;

  typedef struct packed {
    logic [DEF_PIX_W-1:0]        pxmin;
    logic [DEF_PIX_W-1:0]        pxmax;
    logic [DEF_PIX_W-1:0]        pymin;
    logic [DEF_PIX_W-1:0]        pymax;
    logic [DEF_XWIDTH-1:0]       x0;
    logic [DEF_YWIDTH-1:0]       y0;
    logic [DEF_XWIDTH-1:0]       dx;
    logic [DEF_YWIDTH-1:0]       dy;
    logic [DEF_AINV_WIDTH-1:0]   iarea;
    logic [3*DEF_XWIDTH-1:0]     xs;
    logic [3*DEF_YWIDTH-1:0]     ys;
    logic [3*DEF_VAL_WIDTH-1:0]  vals;
  } tri_desc_t;

  typedef struct packed {
    logic                 v;
    logic [DEF_PIX_W-1:0] px;
    logic [DEF_PIX_W-1:0] py;
  } track_ent_t;

endpackage

// File: rtl/raster_track_fifo.sv
// Latency tracker: a DEPTH-deep shift register of {v, px, py} that travels in
// lock-step with the interpolator pipeline, so the tail entry always names the
// pixel whose result the interpolator is presenting right now.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   shift_en    - advance one stage (low while the interpolator is frozen)
//   push_ent    - entry entering stage 0 on a shift (v=0 for a bubble)
//   tail_ent    - oldest entry, aligned with the interpolator output
//   any_valid   - some stage still holds a sample awaiting its result
module raster_track_fifo
  import raster_pkg::*;
#(
  parameter int DEPTH = DEF_LATENCY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  track_ent_t push_ent,
  output track_ent_t tail_ent,
  output logic       any_valid
);

  track_ent_t stage_q [DEPTH];

  // NOTE: this array is a pipeline, not a RAM, so every stage is reset: stale
  // valid bits would otherwise be emitted as pixels and stall the drain check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (shift_en) begin
      stage_q[0] <= push_ent;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_ent = stage_q[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage_q[i].v;
  end

endmodule

// File: rtl/tri_raster_scheduler.sv
// Triangle raster scheduler: walks one triangle's pixel bounding box at one
// sample per cycle, drives the barycentric interpolator's x/y inputs, tracks
// the interpolator's fixed latency to re-attach pixel coordinates to results,
// and emits in-triangle pixels on a valid/ready stream. Downstream backpressure
// becomes interpolator freeze, which also holds the whole scheduler.
//
// Ports:
//   clk_in, rst_n_in           - clock, synchronous active-low reset
//   tri_valid_in/tri_ready_out - descriptor handshake (ready only in IDLE)
//   tri_*_in                   - descriptor: bbox, start point, steps, vertex data
//   bi_x_out, bi_y_out         - sample position to the interpolator
//   bi_iarea/x_tri/y_tri/vals  - latched descriptor fields to the interpolator
//   bi_freeze_out, bi_rst_out  - interpolator freeze, active-high reset
//   bi_val_in, bi_valid_in     - interpolator result and in-triangle flag
//   pix_*                      - output pixel stream (valid/ready)
//   tri_done_out               - one-cycle pulse when a triangle has drained
//   busy_out                   - scheduler not idle
//
// Optional: define RASTER_PERF_CNT_EN to add saturating 32-bit counters
// perf_issued_out, perf_emitted_out and perf_stall_out.
module tri_raster_scheduler
  import raster_pkg::*;
#(
  parameter int XWIDTH     = DEF_XWIDTH,
  parameter int YWIDTH     = DEF_YWIDTH,
  parameter int VAL_WIDTH  = DEF_VAL_WIDTH,
  parameter int AINV_WIDTH = DEF_AINV_WIDTH,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   tri_valid_in,
  output logic                   tri_ready_out,
  input  logic [PIX_W-1:0]       tri_pxmin_in,
  input  logic [PIX_W-1:0]       tri_pxmax_in,
  input  logic [PIX_W-1:0]       tri_pymin_in,
  input  logic [PIX_W-1:0]       tri_pymax_in,
  input  logic [XWIDTH-1:0]      tri_x0_in,
  input  logic [YWIDTH-1:0]      tri_y0_in,
  input  logic [XWIDTH-1:0]      tri_dx_in,
  input  logic [YWIDTH-1:0]      tri_dy_in,
  input  logic [AINV_WIDTH-1:0]  tri_iarea_in,
  input  logic [3*XWIDTH-1:0]    tri_xs_in,
  input  logic [3*YWIDTH-1:0]    tri_ys_in,
  input  logic [3*VAL_WIDTH-1:0] tri_vals_in,
  output logic [XWIDTH-1:0]      bi_x_out,
  output logic [YWIDTH-1:0]      bi_y_out,
  output logic [AINV_WIDTH-1:0]  bi_iarea_out,
  output logic [3*XWIDTH-1:0]    bi_x_tri_out,
  output logic [3*YWIDTH-1:0]    bi_y_tri_out,
  output logic [3*VAL_WIDTH-1:0] bi_vals_out,
  output logic                   bi_freeze_out,
  output logic                   bi_rst_out,
  input  logic [VAL_WIDTH-1:0]   bi_val_in,
  input  logic                   bi_valid_in,
  output logic                   pix_valid_out,
  input  logic                   pix_ready_in,
  output logic [PIX_W-1:0]       pix_x_out,
  output logic [PIX_W-1:0]       pix_y_out,
  output logic [VAL_WIDTH-1:0]   pix_val_out,
  output logic                   tri_done_out,
  output logic                   busy_out
`ifdef RASTER_PERF_CNT_EN
  ,
  output logic [31:0]            perf_issued_out,
  output logic [31:0]            perf_emitted_out,
  output logic [31:0]            perf_stall_out
`endif
);

  raster_state_e state_q, state_d;
  tri_desc_t     desc_in;

  // Only the descriptor fields needed after acceptance are kept.
  logic [PIX_W-1:0]       pxmin_q, pxmax_q, pymax_q;
  logic [XWIDTH-1:0]      x0_q, dx_q;
  logic [YWIDTH-1:0]      dy_q;
  logic [AINV_WIDTH-1:0]  iarea_q;
  logic [3*XWIDTH-1:0]    xs_q;
  logic [3*YWIDTH-1:0]    ys_q;
  logic [3*VAL_WIDTH-1:0] vals_q;

  logic [PIX_W-1:0]  px_q, py_q;
  logic [XWIDTH-1:0] bi_x_q;
  logic [YWIDTH-1:0] bi_y_q;

  logic       accept, issue, freeze, pix_valid, any_valid;
  logic       last_px, last_py, bbox_empty;
  track_ent_t push_ent, tail_ent;

  assign desc_in = '{pxmin: tri_pxmin_in, pxmax: tri_pxmax_in,
                     pymin: tri_pymin_in, pymax: tri_pymax_in,
                     x0: tri_x0_in, y0: tri_y0_in, dx: tri_dx_in, dy: tri_dy_in,
                     iarea: tri_iarea_in, xs: tri_xs_in, ys: tri_ys_in,
                     vals: tri_vals_in};

  assign bbox_empty = (desc_in.pxmin > desc_in.pxmax) || (desc_in.pymin > desc_in.pymax);
  assign accept     = (state_q == IDLE) && tri_valid_in;
  assign last_px    = (px_q == pxmax_q);
  assign last_py    = (py_q == pymax_q);

  // Output side: a result is a pixel only if its tracker entry is a real
  // sample and the interpolator says it lies inside the triangle.
  assign pix_valid = tail_ent.v & bi_valid_in;
  assign freeze    = pix_valid & ~pix_ready_in;
  assign issue     = (state_q == SCAN) && !freeze;

  // ---------------------------------------------------------------- FSM
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values; the reset is synchronous, inside the clocked block.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    tri_done_out = 1'b0;
    unique case (state_q)
      IDLE:  if (tri_valid_in) state_d = bbox_empty ? DRAIN : SCAN;
      SCAN:  if (issue && last_px && last_py) state_d = DRAIN;
      DRAIN: if (!any_valid) begin
        tri_done_out = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- scan datapath
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pxmin_q <= '0;
      pxmax_q <= '0;
      pymax_q <= '0;
      x0_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      iarea_q <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      vals_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      bi_x_q  <= '0;
      bi_y_q  <= '0;
    end else if (accept) begin
      pxmin_q <= desc_in.pxmin;
      pxmax_q <= desc_in.pxmax;
      pymax_q <= desc_in.pymax;
      x0_q    <= desc_in.x0;
      dx_q    <= desc_in.dx;
      dy_q    <= desc_in.dy;
      iarea_q <= desc_in.iarea;
      xs_q    <= desc_in.xs;
      ys_q    <= desc_in.ys;
      vals_q  <= desc_in.vals;
      px_q    <= desc_in.pxmin;
      py_q    <= desc_in.pymin;
      bi_x_q  <= desc_in.x0;
      bi_y_q  <= desc_in.y0;
    end else if (issue) begin
      // On the final pixel nothing moves, so counters never pass the bounds.
      if (!last_px) begin
        px_q   <= px_q + 1'b1;
        bi_x_q <= bi_x_q + dx_q;
      end else if (!last_py) begin
        px_q   <= pxmin_q;
        bi_x_q <= x0_q;
        py_q   <= py_q + 1'b1;
        bi_y_q <= bi_y_q + dy_q;
      end
    end
  end

  // ------------------------------------------------------------- tracker
  // Every unfrozen cycle pushes one entry: the sample being presented during
  // SCAN, a bubble otherwise, keeping the tracker aligned with the pipeline.
  always_comb begin
    push_ent = '0;
    if (issue) push_ent = '{v: 1'b1, px: px_q, py: py_q};
  end

  raster_track_fifo #(
    .DEPTH(LATENCY)
  ) u_track (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .shift_en (!freeze),
    .push_ent (push_ent),
    .tail_ent (tail_ent),
    .any_valid(any_valid)
  );

  // ------------------------------------------------------------- outputs
  assign tri_ready_out = (state_q == IDLE);
  assign busy_out      = (state_q != IDLE);
  assign bi_x_out      = bi_x_q;
  assign bi_y_out      = bi_y_q;
  assign bi_iarea_out  = iarea_q;
  assign bi_x_tri_out  = xs_q;
  assign bi_y_tri_out  = ys_q;
  assign bi_vals_out   = vals_q;
  assign bi_freeze_out = freeze;
  assign bi_rst_out    = !rst_n_in;
  assign pix_valid_out = pix_valid;
  assign pix_x_out     = tail_ent.px;
  assign pix_y_out     = tail_ent.py;
  assign pix_val_out   = bi_val_in;

`ifdef RASTER_PERF_CNT_EN
  // Saturating event counters; they survive across triangles and clear only on reset.
  logic [31:0] perf_issued_q, perf_emitted_q, perf_stall_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      perf_issued_q  <= '0;
      perf_emitted_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (issue && (perf_issued_q != '1))
        perf_issued_q <= perf_issued_q + 1'b1;
      if (pix_valid && pix_ready_in && (perf_emitted_q != '1))
        perf_emitted_q <= perf_emitted_q + 1'b1;
      if (freeze && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_issued_out  = perf_issued_q;
  assign perf_emitted_out = perf_emitted_q;
  assign perf_stall_out   = perf_stall_q;
`endif

endmodule
